s2mm_stream_arb: RTL and testbench



---
 rtl/s2mm_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/s2mm_stream_arb.sv | 157 +++++++++++++++
 tb/tb_s2mm_stream_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2mm_arb_pkg.sv
// Shared types and status-word field positions for the S2MM stream arbiter.
package s2mm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  // status[0] fields
  localparam int ST0_STS_LSB = 0;
  localparam int ST0_OUT_LSB = 8;
  localparam int ST0_PKT_LSB = 16;

  // status[1] fields
  localparam int ST1_GRANT_LSB = 0;
  localparam int ST1_STATE_LSB = 16;
  localparam int ST1_ERR_BIT   = 31;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    logic [IW-1:0] sel;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      sel = IW'(j);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/s2mm_stream_arb.sv
// Round-robin sharing of one S2MM instr/data path among NUM_SRC producers,
// with outstanding-write throttling fed by the datamover status stream.
//
// state | meaning
// IDLE  | arbitrate among instr requesters (only while under the outstanding limit)
// INSTR | pass the granted source's instruction beat
// DATA  | pass the granted source's packet through tlast
module s2mm_stream_arb
  import s2mm_arb_pkg::*;
#(
  parameter  int NUM_SRC          = 4,
  parameter  int CORE_INSTR_WIDTH = 80,
  parameter  int AXI_DATA_WIDTH   = 512,
  parameter  int CORE_STS_WIDTH   = 8,
  parameter  int MAX_OUTSTANDING  = 16,
  localparam int IW               = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_SRC-1:0]                               s_axis_src_instr_tvalid,
  output logic [NUM_SRC-1:0]                               s_axis_src_instr_tready,
  input  logic [NUM_SRC-1:0][CORE_INSTR_WIDTH-1:0]         s_axis_src_instr_tdata,
  input  logic [NUM_SRC-1:0]                               s_axis_src_tvalid,
  output logic [NUM_SRC-1:0]                               s_axis_src_tready,
  input  logic [NUM_SRC-1:0][AXI_DATA_WIDTH-1:0]           s_axis_src_tdata,
  input  logic [NUM_SRC-1:0][AXI_DATA_WIDTH/8-1:0]         s_axis_src_tkeep,
  input  logic [NUM_SRC-1:0]                               s_axis_src_tlast,
  output logic                                             m_axis_s2mm_instr_tvalid,
  input  logic                                             m_axis_s2mm_instr_tready,
  output logic [CORE_INSTR_WIDTH-1:0]                      m_axis_s2mm_instr_tdata,
  output logic                                             m_axis_s2mm_tvalid,
  input  logic                                             m_axis_s2mm_tready,
  output logic [AXI_DATA_WIDTH-1:0]                        m_axis_s2mm_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]                      m_axis_s2mm_tkeep,
  output logic                                             m_axis_s2mm_tlast,
  input  logic                                             s_axis_s2mm_sts_tvalid,
  output logic                                             s_axis_s2mm_sts_tready,
  input  logic [CORE_STS_WIDTH-1:0]                        s_axis_s2mm_sts_tdata,
  output logic [1:0][31:0]                                 status,
  output logic                                             idle
);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [NUM_SRC-1:0] grant_oh_q, grant_oh_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [7:0]         outstanding_q;
  logic [15:0]        pkt_cnt_q;
  logic [7:0]         last_sts_q;
  logic               err_uf_q;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [7:0]         sts8;
  logic               instr_hs, data_hs, sts_hs;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req (s_axis_src_instr_tvalid),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  if (CORE_STS_WIDTH >= 8) begin : g_sts_trunc
    assign sts8 = s_axis_s2mm_sts_tdata[7:0];
  end else begin : g_sts_ext
    assign sts8 = {{(8 - CORE_STS_WIDTH){1'b0}}, s_axis_s2mm_sts_tdata};
  end

  // Status is accepted every cycle out of reset, so the counter never back-pressures the datamover.
  assign s_axis_s2mm_sts_tready = !rst;

  assign m_axis_s2mm_instr_tdata = s_axis_src_instr_tdata[grant_q];
  assign m_axis_s2mm_tdata       = s_axis_src_tdata[grant_q];
  assign m_axis_s2mm_tkeep       = s_axis_src_tkeep[grant_q];
  assign m_axis_s2mm_tlast       = s_axis_src_tlast[grant_q];

  assign instr_hs = m_axis_s2mm_instr_tvalid && m_axis_s2mm_instr_tready;
  assign data_hs  = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
  assign sts_hs   = s_axis_s2mm_sts_tvalid && s_axis_s2mm_sts_tready;

  always_comb begin
    state_d                  = state_q;
    grant_d                  = grant_q;
    grant_oh_d               = grant_oh_q;
    rr_d                     = rr_q;
    m_axis_s2mm_instr_tvalid = 1'b0;
    m_axis_s2mm_tvalid       = 1'b0;
    s_axis_src_instr_tready  = '0;
    s_axis_src_tready        = '0;
    case (state_q)
      IDLE: begin
        if (arb_any && (outstanding_q < 8'(MAX_OUTSTANDING))) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_gnt;
          state_d    = INSTR;
        end
      end
      INSTR: begin
        m_axis_s2mm_instr_tvalid         = s_axis_src_instr_tvalid[grant_q];
        s_axis_src_instr_tready[grant_q] = m_axis_s2mm_instr_tready;
        if (m_axis_s2mm_instr_tvalid && m_axis_s2mm_instr_tready) state_d = DATA;
      end
      DATA: begin
        m_axis_s2mm_tvalid         = s_axis_src_tvalid[grant_q];
        s_axis_src_tready[grant_q] = m_axis_s2mm_tready;
        if (m_axis_s2mm_tvalid && m_axis_s2mm_tready && m_axis_s2mm_tlast) begin
          state_d = IDLE;
          rr_d    = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_oh_q    <= '0;
      rr_q          <= '0;
      outstanding_q <= '0;
      pkt_cnt_q     <= '0;
      last_sts_q    <= '0;
      err_uf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      rr_q       <= rr_d;
      if (instr_hs && !sts_hs) begin
        outstanding_q <= outstanding_q + 8'd1;
      end else if (sts_hs && !instr_hs) begin
        // A status with nothing outstanding is a datamover/software fault; hold at 0 and flag it.
        if (outstanding_q == 8'd0) err_uf_q <= 1'b1;
        else                       outstanding_q <= outstanding_q - 8'd1;
      end
      if (sts_hs) last_sts_q <= sts8;
      if (data_hs && m_axis_s2mm_tlast) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  always_comb begin
    status = '0;
    status[0][ST0_STS_LSB +: 8]  = last_sts_q;
    status[0][ST0_OUT_LSB +: 8]  = outstanding_q;
    status[0][ST0_PKT_LSB +: 16] = pkt_cnt_q;
    if (state_q != IDLE) status[1][ST1_GRANT_LSB +: NUM_SRC] = grant_oh_q;
    status[1][ST1_STATE_LSB +: 8] = {6'd0, state_q};
    status[1][ST1_ERR_BIT]        = err_uf_q;
  end

  assign idle = (state_q == IDLE) && (outstanding_q == 8'd0);

endmodule

// File: tb/tb_s2mm_stream_arb.sv
// Scoreboard bench for s2mm_stream_arb: expected beats and status probes are queued
// by the stimulus process and compared by a negedge monitor.
module tb_s2mm_stream_arb;

  localparam int NS = 4;
  localparam int IWD = 80;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0]          src_instr_tvalid = '0;
  logic [NS-1:0]          src_instr_tready;
  logic [NS-1:0][IWD-1:0] src_instr_tdata = '0;
  logic [NS-1:0]          src_tvalid = '0;
  logic [NS-1:0]          src_tready;
  logic [NS-1:0][DW-1:0]  src_tdata = '0;
  logic [NS-1:0][KW-1:0]  src_tkeep = '0;
  logic [NS-1:0]          src_tlast = '0;
  logic                   m_instr_tvalid;
  logic                   m_instr_tready = 1'b1;
  logic [IWD-1:0]         m_instr_tdata;
  logic                   m_tvalid;
  logic                   m_tready = 1'b1;
  logic [DW-1:0]          m_tdata;
  logic [KW-1:0]          m_tkeep;
  logic                   m_tlast;
  logic                   sts_tvalid = 1'b0;
  logic                   sts_tready;
  logic [SW-1:0]          sts_tdata = '0;
  logic [1:0][31:0]       status;
  logic                   idle;

  always #5 clk = ~clk;

  s2mm_stream_arb #(
    .NUM_SRC(NS), .CORE_INSTR_WIDTH(IWD), .AXI_DATA_WIDTH(DW),
    .CORE_STS_WIDTH(SW), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_src_instr_tvalid(src_instr_tvalid), .s_axis_src_instr_tready(src_instr_tready),
    .s_axis_src_instr_tdata(src_instr_tdata),
    .s_axis_src_tvalid(src_tvalid), .s_axis_src_tready(src_tready),
    .s_axis_src_tdata(src_tdata), .s_axis_src_tkeep(src_tkeep), .s_axis_src_tlast(src_tlast),
    .m_axis_s2mm_instr_tvalid(m_instr_tvalid), .m_axis_s2mm_instr_tready(m_instr_tready),
    .m_axis_s2mm_instr_tdata(m_instr_tdata),
    .m_axis_s2mm_tvalid(m_tvalid), .m_axis_s2mm_tready(m_tready),
    .m_axis_s2mm_tdata(m_tdata), .m_axis_s2mm_tkeep(m_tkeep), .m_axis_s2mm_tlast(m_tlast),
    .s_axis_s2mm_sts_tvalid(sts_tvalid), .s_axis_s2mm_sts_tready(sts_tready),
    .s_axis_s2mm_sts_tdata(sts_tdata),
    .status(status), .idle(idle)
  );

  typedef struct packed {
    logic           is_instr;
    logic [IWD-1:0] instr;
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
  } beat_t;

  typedef struct packed {
    logic [2:0]     src;
    logic [IWD-1:0] instr;
  } exp_i_t;

  typedef struct packed {
    logic [2:0]    src;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_d_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] mask;
    logic [31:0] val;
  } chk_t;

  beat_t  src_q[NS][$];
  exp_i_t exp_instr[$];
  exp_d_t exp_data[$];
  chk_t   chk_q[$];
  string  chk_name_q[$];

  int errors = 0;
  int checks = 0;
  int sts_pending = 0;
  logic [SW-1:0] sts_value = '0;
  logic auto_sts = 1'b0;
  logic toggle = 1'b0;

  // ---------------- monitor ----------------
  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_i_t ei;
    exp_d_t ed;
    chk_t c;
    string nm;
    logic [31:0] act;
    logic [NS-1:0] oh;
    if (!rst && m_instr_tvalid && m_instr_tready) begin
      if (exp_instr.size() == 0) begin
        checks++; errors++;
        $display("FAIL instr_unexpected: got tdata %0h, required no instr beat", m_instr_tdata);
      end else begin
        ei = exp_instr.pop_front();
        oh = NS'(1) << ei.src;
        cmp("instr_tdata", DW'(m_instr_tdata), DW'(ei.instr));
        cmp("instr_grant_status", DW'(status[1][NS-1:0]), DW'(oh));
        cmp("instr_src_tready", DW'(src_instr_tready), DW'(oh));
      end
    end
    if (!rst && m_tvalid && m_tready) begin
      if (exp_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_unexpected: got tdata %0h, required no data beat", m_tdata);
      end else begin
        ed = exp_data.pop_front();
        oh = NS'(1) << ed.src;
        cmp("data_tdata", m_tdata, ed.data);
        cmp("data_tkeep", DW'(m_tkeep), DW'(ed.keep));
        cmp("data_tlast", DW'(m_tlast), DW'(ed.last));
        cmp("data_src_treadys", DW'({src_instr_tready, src_tready}), DW'({{NS{1'b0}}, oh}));
      end
    end
    while (chk_q.size() > 0) begin
      c  = chk_q.pop_front();
      nm = chk_name_q.pop_front();
      case (c.sel)
        2'd0:    act = status[0];
        2'd1:    act = status[1];
        2'd2:    act = {20'h0, src_tready, src_instr_tready, idle, sts_tready, m_tvalid, m_instr_tvalid};
        default: act = {16'(exp_data.size()), 16'(exp_instr.size())};
      endcase
      cmp(nm, DW'(act & c.mask), DW'(c.val));
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_chk(input string name, input logic [1:0] sel, input logic [31:0] mask,
                          input logic [31:0] val);
    chk_name_q.push_back(name);
    chk_q.push_back({sel, mask, val});
  endtask

  task automatic present();
    beat_t b;
    for (int s = 0; s < NS; s++) begin
      src_instr_tvalid[s] = 1'b0;
      src_tvalid[s]       = 1'b0;
      if (src_q[s].size() > 0) begin
        b = src_q[s][0];
        if (b.is_instr) begin
          src_instr_tvalid[s] = 1'b1;
          src_instr_tdata[s]  = b.instr;
        end else begin
          src_tvalid[s] = 1'b1;
          src_tdata[s]  = b.data;
          src_tkeep[s]  = b.keep;
          src_tlast[s]  = b.last;
        end
      end
    end
  endtask

  task automatic step();
    logic [NS-1:0] ihs, dhs;
    logic shs, lhs;
    beat_t b;
    @(negedge clk);
    ihs = src_instr_tvalid & src_instr_tready;
    dhs = src_tvalid & src_tready;
    shs = sts_tvalid & sts_tready;
    lhs = m_tvalid & m_tready & m_tlast;
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++)
      if ((ihs[s] || dhs[s]) && src_q[s].size() > 0) b = src_q[s].pop_front();
    if (shs && sts_pending > 0) sts_pending--;
    if (auto_sts && lhs) sts_pending++;
    sts_tvalid = (sts_pending > 0);
    sts_tdata  = sts_value;
    m_tready   = toggle ? ~m_tready : 1'b1;
    present();
  endtask

  task automatic run_for(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic bit busy();
    bit r = (exp_instr.size() > 0) || (exp_data.size() > 0);
    for (int s = 0; s < NS; s++) if (src_q[s].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic run_drain(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    push_chk(name, 2'd3, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic add_pkt(input int s, input logic [IWD-1:0] instr, input int nbeats,
                         input logic [31:0] base);
    beat_t b;
    logic [KW-1:0] kall;
    logic [31:0] w;
    kall = '1;
    b = '0;
    b.is_instr = 1'b1;
    b.instr    = instr;
    src_q[s].push_back(b);
    exp_instr.push_back({3'(s), instr});
    for (int k = 0; k < nbeats; k++) begin
      w = base + 32'(k);
      b = '0;
      b.data[31:0]   = w;
      b.data[DW-1 -: 32] = ~w;
      b.keep = kall >> (k * 8);
      b.last = (k == nbeats - 1);
      src_q[s].push_back(b);
      exp_data.push_back({3'(s), b.data, b.keep, b.last});
    end
  endtask

  task automatic flush();
    for (int s = 0; s < NS; s++) src_q[s].delete();
    exp_instr.delete();
    exp_data.delete();
    sts_pending = 0;
    sts_tvalid  = 1'b0;
    present();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    auto_sts = 1'b0;
    toggle   = 1'b0;
    flush();
    run_for(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    push_chk("reset_status0", 2'd0, 32'hFFFF_FFFF, 32'h0);
    push_chk("reset_status1", 2'd1, 32'hFFFF_FFFF, 32'h0);
    push_chk("reset_ctrl", 2'd2, 32'h0000_0FFF, 32'h0000_000C);

    // Single packet from src1, one-cycle arbitration latency, then status return
    add_pkt(1, 80'h1111_0000_0000_0000_00A5, 3, 32'h100);
    present();
    push_chk("single_lat_before", 2'd2, 32'h1, 32'h0);
    step();
    push_chk("single_lat_after", 2'd2, 32'h1, 32'h1);
    push_chk("single_instr_state", 2'd1, 32'hFFFF_FFFF, 32'h0001_0002);
    run_drain("single_drain", 40);
    push_chk("single_pkt_out", 2'd0, 32'hFFFF_FF00, 32'h0001_0100);
    push_chk("single_not_idle", 2'd2, 32'h8, 32'h0);
    sts_value   = 8'h80;
    sts_pending = 1;
    run_for(2);
    push_chk("single_sts", 2'd0, 32'hFFFF_FFFF, 32'h0001_0080);
    push_chk("single_idle", 2'd2, 32'h8, 32'h8);

    // Round-robin among four requesters, grant order 0,1,2,3,0
    do_reset();
    auto_sts  = 1'b1;
    sts_value = 8'hC3;
    add_pkt(0, 80'hA0, 1, 32'h0);
    add_pkt(1, 80'hA1, 1, 32'h10);
    add_pkt(2, 80'hA2, 1, 32'h20);
    add_pkt(3, 80'hA3, 1, 32'h30);
    add_pkt(0, 80'hB0, 1, 32'h40);
    run_drain("rr_drain", 80);
    run_for(3);
    push_chk("rr_counts", 2'd0, 32'hFFFF_FFFF, 32'h0005_00C3);

    // Backpressure on the data sink during a 4-beat packet from src2
    do_reset();
    toggle = 1'b1;
    add_pkt(2, 80'hC2, 4, 32'h200);
    run_for(2);
    push_chk("bp_instr_ready_only_src2", 2'd2, 32'h0000_0FF0, 32'h0000_0040);
    add_pkt(0, 80'hC0, 1, 32'h300);
    run_drain("bp_drain", 60);
    push_chk("bp_pkt_count", 2'd0, 32'hFFFF_0000, 32'h0002_0000);

    // Throttle at MAX_OUTSTANDING=2 with no status returned
    do_reset();
    add_pkt(0, 80'hD0, 1, 32'h400);
    add_pkt(1, 80'hD1, 1, 32'h410);
    add_pkt(2, 80'hD2, 1, 32'h420);
    run_for(20);
    push_chk("thr_out_at_limit", 2'd0, 32'h0000_FF00, 32'h0000_0200);
    push_chk("thr_state_idle", 2'd1, 32'h00FF_000F, 32'h0);
    push_chk("thr_one_pending", 2'd3, 32'hFFFF_FFFF, 32'h0001_0001);
    sts_value   = 8'h01;
    sts_pending = 1;
    run_drain("thr_drain", 40);
    push_chk("thr_after_sts", 2'd0, 32'hFFFF_FF00, 32'h0003_0200);

    // Instr and status handshakes in the same cycle with outstanding=1
    sts_pending = 1;
    run_for(4);
    push_chk("sim_pre_out", 2'd0, 32'h0000_FF00, 32'h0000_0100);
    add_pkt(3, 80'hE3, 1, 32'h500);
    step();
    sts_value   = 8'h5A;
    sts_pending = 1;
    step();
    step();
    push_chk("sim_out_hold", 2'd0, 32'h0000_FFFF, 32'h0000_015A);
    push_chk("sim_state_data", 2'd1, 32'h00FF_000F, 32'h0002_0008);
    run_drain("sim_drain", 20);

    // Underflow, then reset in the middle of a packet
    do_reset();
    sts_value   = 8'h7E;
    sts_pending = 1;
    run_for(2);
    push_chk("uf_err", 2'd1, 32'h8000_0000, 32'h8000_0000);
    push_chk("uf_count", 2'd0, 32'hFFFF_FFFF, 32'h0000_007E);
    add_pkt(3, 80'hF3, 4, 32'h600);
    run_for(3);
    push_chk("mid_in_data", 2'd2, 32'h2, 32'h2);
    rst = 1'b1;
    push_chk("sts_ready_in_reset", 2'd2, 32'h4, 32'h0);
    step();
    rst = 1'b0;
    flush();
    push_chk("mid_rst_status0", 2'd0, 32'hFFFF_FFFF, 32'h0);
    push_chk("mid_rst_status1", 2'd1, 32'hFFFF_FFFF, 32'h0);
    push_chk("mid_rst_ctrl", 2'd2, 32'h0000_0FFF, 32'h0000_000C);
    run_for(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
